// File: rtl/mole_hit_judge.sv
// Judges debounced switch events against the live mole pattern and serialises hit points.
// Optional macro HIT_RISING_ONLY_EN: only 0->1 switch transitions are judged.
module mole_hit_judge #(
    parameter int unsigned N_MOLES  = 18,
    parameter int unsigned PEND_W   = 5,
    parameter int unsigned STREAK_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [N_MOLES-1:0]  mole_up,
    input  logic [N_MOLES-1:0]  sw,
    output logic                hit_pulse,
    output logic                miss_pulse,
    output logic [N_MOLES-1:0]  mole_visible,
    output logic [N_MOLES-1:0]  hit_mask,
    output logic [STREAK_W-1:0] streak,
    output logic                busy
);
    localparam int unsigned CNT_W = $clog2(N_MOLES + 1);
    localparam int unsigned SUM_W = ((PEND_W > CNT_W) ? PEND_W : CNT_W) + 1;
    localparam int unsigned STK_W = ((STREAK_W > CNT_W) ? STREAK_W : CNT_W) + 1;
    localparam logic [PEND_W-1:0]   PendMax   = '1;
    localparam logic [STREAK_W-1:0] StreakMax = '1;

    typedef enum logic [1:0] {StIdle, StPlay, StDrain} state_e;

    state_e              state_q;
    logic [N_MOLES-1:0]  sw_q;
    logic [PEND_W-1:0]   pending_q;

    logic [N_MOLES-1:0]  evt;
    logic [N_MOLES-1:0]  hit_lanes;
    logic [N_MOLES-1:0]  miss_lanes;
    logic [CNT_W-1:0]    new_hits;
    logic [SUM_W-1:0]    total;
    logic [SUM_W-1:0]    total_m1;
    logic [PEND_W-1:0]   pend_next;
    logic [STK_W-1:0]    streak_sum;
    logic [STREAK_W-1:0] streak_sat;

    always_comb begin
`ifdef HIT_RISING_ONLY_EN
        evt = sw & ~sw_q;
`else
        evt = sw ^ sw_q;
`endif
        hit_lanes  = '0;
        miss_lanes = '0;
        if (state_q == StPlay) begin
            hit_lanes  = evt & mole_up & ~hit_mask;
            miss_lanes = evt & ~mole_up;
        end

        new_hits = '0;
        for (int i = 0; i < int'(N_MOLES); i++) begin
            new_hits = new_hits + CNT_W'(hit_lanes[i]);
        end

        total    = SUM_W'(pending_q) + SUM_W'(new_hits);
        total_m1 = total - SUM_W'(1);
        // Pending holds the points still owed after this cycle's pulse.
        if (total == '0) begin
            pend_next = '0;
        end else if (total_m1 > SUM_W'(PendMax)) begin
            pend_next = PendMax;
        end else begin
            pend_next = total_m1[PEND_W-1:0];
        end

        streak_sum = STK_W'(streak) + STK_W'(new_hits);
        streak_sat = (streak_sum > STK_W'(StreakMax)) ? StreakMax : streak_sum[STREAK_W-1:0];
    end

    assign mole_visible = mole_up & ~hit_mask;

    always_ff @(posedge clk) begin
        // Tracks sw even in reset so releasing reset never looks like a switch event.
        sw_q <= sw;
        if (!reset_n) begin
            state_q    <= StIdle;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            busy       <= 1'b0;
            streak     <= '0;
            hit_mask   <= '0;
            pending_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    hit_pulse  <= 1'b0;
                    miss_pulse <= 1'b0;
                    busy       <= 1'b0;
                    streak     <= '0;
                    hit_mask   <= '0;
                    pending_q  <= '0;
                    if (enable) state_q <= StPlay;
                end
                StPlay: begin
                    hit_mask   <= (hit_mask | hit_lanes) & mole_up;
                    hit_pulse  <= (total != '0);
                    pending_q  <= pend_next;
                    busy       <= (pend_next != '0);
                    miss_pulse <= |miss_lanes;
                    streak     <= (|miss_lanes) ? '0 : streak_sat;
                    if (!enable) begin
                        state_q <= (total > SUM_W'(1)) ? StDrain : StIdle;
                    end
                end
                StDrain: begin
                    hit_mask   <= hit_mask & mole_up;
                    hit_pulse  <= (total != '0);
                    pending_q  <= pend_next;
                    busy       <= (pend_next != '0);
                    miss_pulse <= 1'b0;
                    if (pend_next == '0) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mole_hit_judge.sv
// Directed self-checking bench for mole_hit_judge; expectations follow HIT_RISING_ONLY_EN.
module tb_mole_hit_judge;
    localparam int N = 18;
`ifdef HIT_RISING_ONLY_EN
    localparam bit RISE = 1'b1;
`else
    localparam bit RISE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic [N-1:0] mole_up;
    logic [N-1:0] sw;
    logic         hit_pulse;
    logic         miss_pulse;
    logic [N-1:0] mole_visible;
    logic [N-1:0] hit_mask;
    logic [3:0]   streak;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    mole_hit_judge dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .mole_up      (mole_up),
        .sw           (sw),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse),
        .mole_visible (mole_visible),
        .hit_mask     (hit_mask),
        .streak       (streak),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; sw = '1; mole_up = '0;
        tick(); tick();
        vectors++;
        if ({hit_pulse, miss_pulse, busy, streak, hit_mask} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got p=%b m=%b b=%b s=%0d mask=%h, want all 0",
                     hit_pulse, miss_pulse, busy, streak, hit_mask);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({hit_pulse, miss_pulse, busy, streak, hit_mask, mole_visible} !== '0) begin
                miscompares++;
                $display("FAIL post_reset_quiet[%0d]: got p=%b m=%b b=%b s=%0d, want all 0",
                         i, hit_pulse, miss_pulse, busy, streak);
            end
        end
        // All switches fall with no mole up.
        sw = '0;
        tick();
        vectors++;
        if (miss_pulse !== !RISE) begin
            miscompares++;
            $display("FAIL falling_miss: got %b want %b", miss_pulse, !RISE);
        end
        tick();
        vectors++;
        if (miss_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL miss_one_cycle: got %b want 0", miss_pulse);
        end
    endtask

    task automatic test_single_hit();
        mole_up = 18'h00010;
        tick();
        vectors++;
        if (mole_visible !== 18'h00010) begin
            miscompares++;
            $display("FAIL visible_before_hit: got %h want 00010", mole_visible);
        end
        sw[4] = 1'b1;
        tick();
        vectors++;
        if ({hit_pulse, streak, hit_mask, mole_visible} !== {1'b1, 4'd1, 18'h00010, 18'h0}) begin
            miscompares++;
            $display("FAIL single_hit: got p=%b s=%0d mask=%h vis=%h want 1 1 00010 00000",
                     hit_pulse, streak, hit_mask, mole_visible);
        end
        tick();
        vectors++;
        if (hit_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pulse_width: got %b want 0", hit_pulse);
        end
        mole_up = '0;
        tick();
        vectors++;
        if (hit_mask !== '0) begin
            miscompares++;
            $display("FAIL mask_clear_on_drop: got %h want 00000", hit_mask);
        end
    endtask

    task automatic test_burst();
        bit exp_p [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        bit exp_b [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        mole_up = 18'h0000F;
        sw = sw | 18'h0000F;
        tick();
        vectors++;
        if ({hit_pulse, busy, streak} !== {1'b1, 1'b1, 4'd5}) begin
            miscompares++;
            $display("FAIL burst_first: got p=%b b=%b s=%0d want 1 1 5", hit_pulse, busy, streak);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({hit_pulse, busy} !== {exp_p[i], exp_b[i]}) begin
                miscompares++;
                $display("FAIL burst_seq[%0d]: got p=%b b=%b want %b %b",
                         i, hit_pulse, busy, exp_p[i], exp_b[i]);
            end
        end
        sw[0] = 1'b0;
        tick();
        vectors++;
        if ({hit_pulse, miss_pulse, streak, hit_mask} !== {2'b00, 4'd5, 18'h0000F}) begin
            miscompares++;
            $display("FAIL double_whack: got p=%b m=%b s=%0d mask=%h want 0 0 5 0000f",
                     hit_pulse, miss_pulse, streak, hit_mask);
        end
    endtask

    task automatic test_miss_priority();
        mole_up = 18'h00020;
        tick();
        sw[5] = 1'b1;
        sw[6] = 1'b1;
        tick();
        vectors++;
        if ({hit_pulse, miss_pulse, streak, hit_mask} !== {2'b11, 4'd0, 18'h00020}) begin
            miscompares++;
            $display("FAIL miss_priority: got p=%b m=%b s=%0d mask=%h want 1 1 0 00020",
                     hit_pulse, miss_pulse, streak, hit_mask);
        end
        tick();
        vectors++;
        if ({hit_pulse, miss_pulse} !== 2'b00) begin
            miscompares++;
            $display("FAIL miss_priority_after: got p=%b m=%b want 0 0", hit_pulse, miss_pulse);
        end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        mole_up = '0; sw = '0;
        tick();
        mole_up = '1; sw = '1;
        tick();
        pulses += int'(hit_pulse);
        vectors++;
        if (streak !== 4'd15) begin
            miscompares++;
            $display("FAIL streak_saturate: got %0d want 15", streak);
        end
        mole_up = '0; sw = '0;
        tick();
        pulses += int'(hit_pulse);
        vectors++;
        if ({miss_pulse, streak} !== {!RISE, (RISE ? 4'd15 : 4'd0)}) begin
            miscompares++;
            $display("FAIL sat_mid_miss: got m=%b s=%0d want %b %0d",
                     miss_pulse, streak, !RISE, RISE ? 15 : 0);
        end
        mole_up = '1; sw = '1;
        tick();
        pulses += int'(hit_pulse);
        for (int i = 0; i < 45; i++) begin
            tick();
            pulses += int'(hit_pulse);
        end
        vectors++;
        if (pulses !== 34) begin
            miscompares++;
            $display("FAIL pending_saturate: got %0d pulses want 34", pulses);
        end
        vectors++;
        if ({busy, hit_pulse, streak} !== {2'b00, 4'd15}) begin
            miscompares++;
            $display("FAIL sat_idle_end: got b=%b p=%b s=%0d want 0 0 15", busy, hit_pulse, streak);
        end
    endtask

    task automatic test_drain();
        mole_up = '0; sw = '0;
        tick();
        mole_up = 18'h00007;
        tick();
        sw = 18'h00007;
        tick();
        vectors++;
        if ({hit_pulse, busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL drain_first: got p=%b b=%b want 1 1", hit_pulse, busy);
        end
        enable = 1'b0;
        tick();
        vectors++;
        if ({hit_pulse, hit_mask} !== {1'b1, 18'h00007}) begin
            miscompares++;
            $display("FAIL drain_second: got p=%b mask=%h want 1 00007", hit_pulse, hit_mask);
        end
        // Toggles during drain: a would-be miss on lane 8 and a release on lane 0.
        sw = 18'h00106;
        tick();
        vectors++;
        if ({hit_pulse, miss_pulse, busy, hit_mask, streak} !==
            {3'b100, 18'h00007, (RISE ? 4'd15 : 4'd3)}) begin
            miscompares++;
            $display("FAIL drain_third: got p=%b m=%b b=%b mask=%h s=%0d want 1 0 0 00007 %0d",
                     hit_pulse, miss_pulse, busy, hit_mask, streak, RISE ? 15 : 3);
        end
        tick();
        vectors++;
        if ({hit_pulse, miss_pulse, streak, hit_mask} !== '0) begin
            miscompares++;
            $display("FAIL drain_to_idle: got p=%b m=%b s=%0d mask=%h want 0 0 0 00000",
                     hit_pulse, miss_pulse, streak, hit_mask);
        end
    endtask

    task automatic test_reset_mid_drain();
        enable = 1'b1;
        tick();
        mole_up = 18'h00038;
        sw = sw | 18'h00038;
        tick();
        vectors++;
        if ({hit_pulse, busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL rmd_first: got p=%b b=%b want 1 1", hit_pulse, busy);
        end
        enable = 1'b0;
        tick();
        vectors++;
        if ({hit_pulse, busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL rmd_drain: got p=%b b=%b want 1 1", hit_pulse, busy);
        end
        reset_n = 1'b0;
        tick();
        vectors++;
        if ({hit_pulse, busy, streak, hit_mask} !== '0) begin
            miscompares++;
            $display("FAIL rmd_reset: got p=%b b=%b s=%0d mask=%h want 0 0 0 00000",
                     hit_pulse, busy, streak, hit_mask);
        end
        reset_n = 1'b1;
        tick();
        vectors++;
        if (hit_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL rmd_after: got p=%b want 0", hit_pulse);
        end
    endtask

    task automatic test_feature();
        enable = 1'b1;
        tick();
        mole_up = 18'h00100;
        tick();
        sw[8] = 1'b0;
        tick();
        vectors++;
        if ({hit_pulse, miss_pulse} !== {!RISE, 1'b0}) begin
            miscompares++;
            $display("FAIL falling_edge_hit: got p=%b m=%b want %b 0", hit_pulse, miss_pulse, !RISE);
        end
        tick();
        sw[8] = 1'b1;
        tick();
        vectors++;
        if ({hit_pulse, miss_pulse} !== {RISE, 1'b0}) begin
            miscompares++;
            $display("FAIL rising_edge_hit: got p=%b m=%b want %b 0", hit_pulse, miss_pulse, RISE);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_hit();
        test_burst();
        test_miss_priority();
        test_saturation();
        test_drain();
        test_reset_mid_drain();
        test_feature();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
